// File: rtl/cpu_mem_bridge_pkg.sv
// cpu_mem_bridge_pkg
// Shared definitions for the CPU-to-memory bridge:
//   - bridge FSM state enum and the MSB position of its encoding
//   - CPU read/write direction encoding (same values the core drives)
//   - all-ones fill pattern returned to the core on an aborted read
//   - counter width helper used by the wait/timeout timer
package cpu_mem_bridge_pkg;

  // MSB position of the bridge state encoding
  localparam int BRIDGE_ST_MP = 1;

  typedef enum logic [BRIDGE_ST_MP:0] {
    BR_ST_IDLE  = 2'd0,
    BR_ST_SETUP = 2'd1,
    BR_ST_WAIT  = 2'd2,
    BR_ST_DONE  = 2'd3
  } bridge_state_e;

  // Direction encoding of cpu_which_rdwr
  localparam logic ENUM__CPU_WH_RDWR__READ  = 1'b0;
  localparam logic ENUM__CPU_WH_RDWR__WRITE = 1'b1;

  // Abort read fill; sliced down to the data width by the user
  localparam logic [63:0] ABORT_FILL_ALL = '1;

  // Bits needed to hold 0..max_val, never less than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_mem_wait_timer.sv
// cpu_mem_wait_timer
// Wait-state down-counter and timeout up-counter for one bridge access.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : reload wait counter with WAIT_STATES, clear timeout counter
//   run        : one WAIT cycle elapsed (decrement wait, increment timeout)
//   wait_done  : wait counter has reached zero
//   timed_out  : timeout counter sits at TIMEOUT_CYCLES-1
module cpu_mem_wait_timer
  import cpu_mem_bridge_pkg::*;
#(
  parameter int WAIT_STATES    = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic wait_done,
  output logic timed_out
);

  localparam int WW = cnt_width(WAIT_STATES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(WAIT_STATES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Both counters saturate: wait stops at zero, timeout stops at its last
  // value, so neither can wrap while the FSM lingers.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (load) begin
      wait_cnt_d = WAIT_INIT;
      tmo_cnt_d  = '0;
    end else if (run) begin
      if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - WW'(1);
      if (tmo_cnt_q != TMO_LAST) tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign wait_done = (wait_cnt_q == '0);
  assign timed_out = (tmo_cnt_q == TMO_LAST);

endmodule

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge
// Runs one CPU request at a time against an 8-bit synchronous memory with
// programmable wait states and a ready handshake; stalls the core via
// cpu_enable and aborts stuck accesses with a sticky bus error.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   cpu_req_rdwr, cpu_which_rdwr  : core request strobe and direction (1=write)
//   cpu_addr, cpu_data_out        : core address and write data
//   cpu_data_in                   : registered read data to the core
//   cpu_enable                    : core advance enable
//   mem_cs, mem_we, mem_addr,
//   mem_wdata                     : registered memory request
//   mem_rdata, mem_ready          : memory read data and completion
//   bus_err_clr, bus_err          : clear input and sticky timeout flag
module cpu_mem_bridge
  import cpu_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int WAIT_STATES    = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_rdwr,
  input  logic                  cpu_which_rdwr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic                  cpu_enable,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  input  logic                  bus_err_clr,
  output logic                  bus_err
);

  localparam logic [DATA_WIDTH-1:0] ABORT_FILL = ABORT_FILL_ALL[DATA_WIDTH-1:0];

  bridge_state_e         state_q, state_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] cpu_data_in_q, cpu_data_in_d;
  logic                  bus_err_q, bus_err_d;
  logic                  abort;
  logic                  wait_done;
  logic                  timed_out;

  cpu_mem_wait_timer #(
    .WAIT_STATES   (WAIT_STATES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == BR_ST_SETUP),
    .run      (state_q == BR_ST_WAIT),
    .wait_done(wait_done),
    .timed_out(timed_out)
  );

  // mem_cs/mem_we are registered, so they are set on the edge into SETUP and
  // cleared on the edge into DONE.
  always_comb begin
    state_d       = state_q;
    mem_cs_d      = mem_cs_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_data_in_d = cpu_data_in_q;
    abort         = 1'b0;
    case (state_q)
      BR_ST_IDLE: begin
        if (cpu_req_rdwr) begin
          mem_addr_d  = cpu_addr;
          mem_we_d    = cpu_which_rdwr;
          mem_wdata_d = cpu_data_out;
          mem_cs_d    = 1'b1;
          state_d     = BR_ST_SETUP;
        end
      end
      BR_ST_SETUP: state_d = BR_ST_WAIT;
      BR_ST_WAIT: begin
        // Completion is checked first so it wins over a coincident abort
        if (wait_done && mem_ready) begin
          if (mem_we_q == ENUM__CPU_WH_RDWR__READ) cpu_data_in_d = mem_rdata;
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = BR_ST_DONE;
        end else if (timed_out) begin
          if (mem_we_q == ENUM__CPU_WH_RDWR__READ) cpu_data_in_d = ABORT_FILL;
          abort    = 1'b1;
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          state_d  = BR_ST_DONE;
        end
      end
      default: state_d = BR_ST_IDLE;
    endcase
    // A new abort beats a simultaneous clear
    bus_err_d = abort ? 1'b1 : (bus_err_clr ? 1'b0 : bus_err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BR_ST_IDLE;
      mem_cs_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_data_in_q <= '0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_cs_q      <= mem_cs_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_data_in_q <= cpu_data_in_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Combinational so the core freezes in the same cycle its request appears
  assign cpu_enable  = !rst && (((state_q == BR_ST_IDLE) && !cpu_req_rdwr) ||
                                (state_q == BR_ST_DONE));
  assign mem_cs      = mem_cs_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_data_in = cpu_data_in_q;
  assign bus_err     = bus_err_q;

endmodule

// File: doc/cpu_mem_bridge.md
# cpu_mem_bridge

Memory-side bridge that sits directly downstream of the CPU core. It accepts the core's `req_rdwr` / `which_rdwr` / `addr` / `data_out` request outputs and runs one transaction at a time against an external 8-bit synchronous memory with programmable wait states and a ready handshake. It stalls the core through its `enable` input until the access completes, then returns read data on the core's `data_in`. A timeout watchdog aborts stuck accesses and raises a sticky bus-error flag.

## Interface
- `ADDR_WIDTH`, 16, CPU/memory address width (24 later).
- `DATA_WIDTH`, 8, data width.
- `WAIT_STATES`, 2, minimum wait cycles before `mem_ready` is honoured; 0..15.
- `TIMEOUT_CYCLES`, 32, maximum WAIT-state cycles before abort; must be > `WAIT_STATES`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req_rdwr` in 1: core request strobe.
- `cpu_which_rdwr` in 1: read = 0, write = 1 (`ENUM__CPU_WH_RDWR__*`).
- `cpu_addr` in ADDR_WIDTH: request address.
- `cpu_data_out` in DATA_WIDTH: write data from core.
- `cpu_data_in` out DATA_WIDTH: registered read data to core.
- `cpu_enable` out 1: core advance enable (combinational).
- `mem_cs` out 1: memory chip select.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_rdata` in DATA_WIDTH: memory read data.
- `mem_ready` in 1: memory completion.
- `bus_err_clr` in 1: clears `bus_err`.
- `bus_err` out 1: sticky timeout flag.

## Operation
- **Reset values:** state IDLE; `cpu_data_in`, `mem_cs`, `mem_we`, `mem_addr`, `mem_wdata`, `bus_err`, counters all 0; `cpu_enable` forced 0 while `rst` is high. Reset mid-transaction aborts immediately and drops `mem_cs` asynchronously. No completion is reported.
- **`cpu_enable`** = (IDLE && !`cpu_req_rdwr`) || DONE; 0 in SETUP and WAIT. The core is frozen in the same cycle its request appears, so request inputs stay stable.
- **IDLE:** `mem_cs` = 0. If `cpu_req_rdwr`, latch `cpu_addr` into `mem_addr`, `cpu_which_rdwr` into `mem_we`, and `cpu_data_out` into `mem_wdata`, then go to SETUP.
- **SETUP:** `mem_cs` = 1. Load wait counter = `WAIT_STATES`, timeout counter = 0, then go to WAIT.
- **WAIT:** `mem_cs` = 1; timeout counter increments each cycle.
  - If wait counter ≠ 0, decrement it.
  - Otherwise, if `mem_ready`: for a read, `cpu_data_in` <= `mem_rdata`; go to DONE.
  - Abort when the timeout counter reaches `TIMEOUT_CYCLES - 1` without completion: for a read, `cpu_data_in` <= all-ones; set `bus_err`; go to DONE.
  - Completion takes priority over abort in the same cycle.
- **DONE:** `mem_cs` = 0, `mem_we` = 0, `cpu_enable` = 1 for exactly one cycle, then go to IDLE. A write leaves `cpu_data_in` unchanged.
- **Back-to-back:** if the core holds `cpu_req_rdwr` high after DONE, IDLE accepts it as a new transaction. There is no gap beyond the IDLE cycle.
- **`bus_err`:** set on abort, cleared by `bus_err_clr`. If set and clear occur in the same cycle, set wins.
- `mem_ready` outside WAIT is ignored.

## Timing
- Request seen in IDLE at cycle 0 → SETUP at cycle 1 → WAIT from cycle 2 → DONE at cycle `WAIT_STATES` + 3 with zero-latency ready.
- Each extra cycle of `mem_ready` low adds one cycle.
- Stall length = number of cycles `cpu_enable` is low = `WAIT_STATES` + 3 minimum.
- Read data is valid on `cpu_data_in` from the DONE cycle until the next read capture.
- Aborted access: DONE at cycle `TIMEOUT_CYCLES` + 2.
- Counters are sized with `$clog2` of their maximum and never wrap: wait decrements saturate at 0, and timeout terminates before overflow.

## Structure
- **Shared include (`src/inc`):** bridge state enum (IDLE, SETUP, WAIT, DONE) and its MSB position, in the same `_ENUM_MP__` / enum-list style as the CPU states. Reuse the existing `ENUM__CPU_WH_RDWR__READ/WRITE` encoding. Add the abort read-fill constant (all-ones).
- **Sub-module `cpu_mem_wait_timer`:** holds the wait-state down-counter and timeout up-counter. Inputs are load/run; outputs are `wait_done` and `timed_out`.
- The top level holds the FSM, request latches, data capture and `bus_err`.

## Test plan
- **Read, `WAIT_STATES` = 2, `mem_ready` tied high, addr 0x2329, `mem_rdata` 0x5A** → `mem_cs` high cycles 1–4; DONE at cycle 5 with `cpu_data_in` = 0x5A; `cpu_enable` low cycles 0–4 and high at cycle 5.
- **Write of 0xA5 to 0x9001** → `mem_we` = 1, `mem_addr` = 0x9001 and `mem_wdata` = 0xA5 throughout SETUP/WAIT; `cpu_data_in` unchanged.
- **Read with `mem_ready` low for 4 extra cycles** → DONE at cycle 9 with correct data; `bus_err` stays 0.
- **`mem_ready` never asserted, `TIMEOUT_CYCLES` = 32** → DONE at cycle 34 with `cpu_data_in` = 0xFF and `bus_err` = 1. Pulsing `bus_err_clr` clears it. Clear coinciding with a new abort leaves it at 1.
- **Three back-to-back reads with the request held high** → three DONE pulses at cycles 5, 11 and 17, each returning its own data.
- **`rst` asserted mid-WAIT (asynchronously, between edges)** → `mem_cs` drops immediately; with `rst` released, the FSM is in IDLE and outputs are at reset values with no DONE pulse.
